// File: rtl/bcd_to_binary_pkg.sv
// ----------------------------------------------------------------------------
// bcd_to_binary_pkg
// Shared definitions for the packed-BCD to binary converter.
//   - state_e       : FSM encoding. It matches the binary-to-BCD block, so one
//                     debug decoder can serve both directions.
//   - BCD_DIGIT_MAX : largest legal decimal digit.
//   - DIGITS_DEF / BIN_W_DEF : default geometry (4 digits -> 14-bit result).
// ----------------------------------------------------------------------------
package bcd_to_binary_pkg;

  localparam int DIGITS_DEF = 4;
  localparam int BIN_W_DEF  = 14;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_INIT  = 3'b001,
    ST_SHIFT = 3'b011,
    ST_CHECK = 3'b010,
    ST_DONE  = 3'b110
  } state_e;

endpackage

// File: rtl/bcd_nibble_sub3.sv
// ----------------------------------------------------------------------------
// bcd_nibble_sub3
// Correction cell for reverse double dabble: subtracts 3 from a nibble that
// reads 8 or more after a right shift, otherwise passes it through.
//   nib_i : nibble after shift
//   nib_o : corrected nibble
// ----------------------------------------------------------------------------
module bcd_nibble_sub3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  // nib_i >= 8 is just bit 3; the subtract cannot underflow.
  assign nib_o = nib_i[3] ? (nib_i - 4'd3) : nib_i;

endmodule

// File: rtl/bcd_to_binary.sv
// ----------------------------------------------------------------------------
// bcd_to_binary
// Sequential packed-BCD to binary converter (reverse double dabble: shift
// right, subtract 3 from any digit >= 8). One conversion per START accepted
// in Idle; the result is held until the next successful conversion.
//   CLK    : system clock
//   RST    : synchronous active-high reset, aborts a conversion immediately
//   START  : conversion request, sampled only in Idle
//   BCDIN  : packed BCD, most significant digit in the top nibble
//   BINOUT : registered binary result (unchanged on an invalid request)
//   BUSY   : high whenever the FSM is not Idle
//   DONE   : one-cycle pulse when a conversion finishes (valid or not)
//   ERR    : last accepted request held a digit > 9; cleared on next START
// Latency from START sampled at edge k: DONE after edge k+30 for valid input,
// after edge k+2 for invalid input.
// ----------------------------------------------------------------------------
module bcd_to_binary
  import bcd_to_binary_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  // Must satisfy 2**BIN_W > 10**DIGITS - 1; also the number of shifts.
  parameter int BIN_W  = BIN_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [4*DIGITS-1:0]   BCDIN,
  output logic [BIN_W-1:0]      BINOUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int BCD_W = 4*DIGITS;
  localparam int WRK_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W);

  state_e                     state_q, state_d;
  logic [DIGITS-1:0][3:0]     bcd_q, bcd_d;
  logic [BIN_W-1:0]           bin_q, bin_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [BIN_W-1:0]           binout_q, binout_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  logic [DIGITS-1:0][3:0]     bcd_sub;
  logic [DIGITS-1:0]          dig_bad;
  logic [WRK_W-1:0]           wrk_shr;

  // Per-digit correction cells and input digit range check.
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bcd_nibble_sub3 u_sub3 (
        .nib_i (bcd_q[g]),
        .nib_o (bcd_sub[g])
      );
      assign dig_bad[g] = (BCDIN[4*g +: 4] > BCD_DIGIT_MAX);
    end
  endgenerate

  // Whole working register shifted right: bcd LSB drops into bin MSB.
  assign wrk_shr = {bcd_q, bin_q} >> 1;

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    binout_d = binout_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (START) state_d = ST_INIT;
      end
      ST_INIT: begin
        bcd_d = BCDIN;
        bin_d = '0;
        cnt_d = '0;
        err_d = 1'b0;
        if (|dig_bad) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d   = wrk_shr[WRK_W-1:BIN_W];
        bin_d   = wrk_shr[BIN_W-1:0];
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        // No correction after the final shift; the bcd field is empty then.
        if (cnt_q != CNT_LAST) begin
          bcd_d   = bcd_sub;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!err_q) binout_d = bin_q;
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      bcd_q    <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      binout_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      binout_q <= binout_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign BINOUT = binout_q;
  assign BUSY   = (state_q != ST_IDLE);
  assign DONE   = done_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// ----------------------------------------------------------------------------
// tb_bcd_to_binary
// Self-checking bench for bcd_to_binary: vector table, hand-written corner
// sequences (ignored START, reset abort, back-to-back), and random requests
// compared against a decimal-arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_bcd_to_binary;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [15:0] BCDIN = '0;
  logic [13:0] BINOUT;
  logic        BUSY, DONE, ERR;

  int checks   = 0;
  int failures = 0;

  bcd_to_binary #(.DIGITS(4), .BIN_W(14)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .BCDIN  (BCDIN),
    .BINOUT (BINOUT),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .ERR    (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] bcd;
    int          bin;
    int          err;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: decimal value of a packed BCD word; bad if any digit > 9.
  function automatic void ref_conv(input logic [15:0] b, output int bad, output int val);
    int w;
    int d;
    bad = 0;
    val = 0;
    w   = 1;
    for (int i = 0; i < 4; i++) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) bad = 1;
      val += d * w;
      w   *= 10;
    end
  endfunction

  // Stand-in for the binary-to-BCD block: decimal digits of v, packed.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // One START pulse; returns edges from START sample to DONE visible and
  // the number of those cycles with BUSY high. Bounded at 100 cycles.
  task automatic run(input logic [15:0] b, output int lat, output int busy);
    @(negedge CLK);
    BCDIN = b;
    START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    lat  = 0;
    busy = 0;
    while (!DONE && lat < 100) begin
      if (BUSY) busy++;
      @(negedge CLK);
      lat++;
    end
  endtask

  vec_t vt[9];
  int   lat, busy, bad, val, model_bin, n, pulses, first_at;
  logic [15:0] b;

  initial begin
    vt[0] = '{16'h1234, 1234, 0, 30};
    vt[1] = '{16'h9999, 9999, 0, 30};
    vt[2] = '{16'h0000,    0, 0, 30};
    vt[3] = '{16'h1234, 1234, 0, 30};
    vt[4] = '{16'h12A4, 1234, 1,  2};
    vt[5] = '{16'h0500,  500, 0, 30};
    vt[6] = '{16'hF000,  500, 1,  2};
    vt[7] = '{16'h0009,    9, 0, 30};
    vt[8] = '{16'h8000, 8000, 0, 30};

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_binout", int'(BINOUT), 0);
    chk("rst_busy",   int'(BUSY),   0);
    chk("rst_done",   int'(DONE),   0);
    chk("rst_err",    int'(ERR),    0);

    // Vector table
    for (int i = 0; i < 9; i++) begin
      run(vt[i].bcd, lat, busy);
      chk($sformatf("tbl%0d_lat", i),    lat,          vt[i].lat);
      chk($sformatf("tbl%0d_busy", i),   busy,         vt[i].lat);
      chk($sformatf("tbl%0d_binout", i), int'(BINOUT), vt[i].bin);
      chk($sformatf("tbl%0d_err", i),    int'(ERR),    vt[i].err);
      @(negedge CLK);
      chk($sformatf("tbl%0d_done_1cyc", i), int'(DONE), 0);
    end

    // START during a conversion with changed BCDIN is ignored.
    @(negedge CLK);
    BCDIN = 16'h1234;
    START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    pulses = 0;
    first_at = -1;
    for (int c = 0; c < 60; c++) begin
      if (c == 10) begin
        BCDIN = 16'h5678;
        START = 1'b1;
      end else begin
        START = 1'b0;
      end
      if (DONE) begin
        pulses++;
        if (first_at < 0) first_at = c;
      end
      @(negedge CLK);
    end
    chk("ign_pulses", pulses,       1);
    chk("ign_lat",    first_at,     30);
    chk("ign_binout", int'(BINOUT), 1234);

    // Reset mid-conversion aborts with no DONE.
    run(16'h0500, lat, busy);     // BINOUT = 500 beforehand, nonzero
    @(negedge CLK);
    BCDIN = 16'h0500;
    START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    repeat (14) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_binout", int'(BINOUT), 0);
    chk("abort_busy",   int'(BUSY),   0);
    chk("abort_done",   int'(DONE),   0);
    chk("abort_err",    int'(ERR),    0);
    RST = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (DONE) pulses++;
      @(negedge CLK);
    end
    chk("abort_no_done", pulses, 0);
    run(16'h0500, lat, busy);
    chk("abort_redo_lat",    lat,          30);
    chk("abort_redo_binout", int'(BINOUT), 500);
    model_bin = 500;

    // Random requests, mixing round-trip values and arbitrary nibbles.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) b = 16'($urandom);
      else b = to_bcd(int'($urandom_range(0, 9999)));
      ref_conv(b, bad, val);
      if (bad == 0) model_bin = val;
      run(b, lat, busy);
      chk($sformatf("rnd%0d_lat", i),    lat,          bad ? 2 : 30);
      chk($sformatf("rnd%0d_binout", i), int'(BINOUT), model_bin);
      chk($sformatf("rnd%0d_err", i),    int'(ERR),    bad);
    end

    // START held high: back-to-back conversions every 31 cycles.
    @(negedge CLK);
    val   = int'($urandom_range(0, 9999));
    BCDIN = to_bcd(val);
    START = 1'b1;
    n = 0;
    while (!DONE && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("b2b_first_binout", int'(BINOUT), val);
    for (int i = 0; i < 20; i++) begin
      val   = (i == 0) ? 9999 : (i == 1) ? 0 : int'($urandom_range(0, 9999));
      BCDIN = to_bcd(val);
      n = 0;
      do begin
        @(negedge CLK);
        n++;
      end while (!DONE && n < 100);
      chk($sformatf("b2b%0d_period", i), n,            31);
      chk($sformatf("b2b%0d_binout", i), int'(BINOUT), val);
      chk($sformatf("b2b%0d_err", i),    int'(ERR),    0);
    end
    START = 1'b0;
    repeat (40) @(negedge CLK);
    chk("b2b_idle", int'(BUSY), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
